gsim_frame_loader: RTL and testbench

- Upstream feeder for the GSIM solver. Accepts the 8x8 coefficient matrix A and vector b one row per handshake over a narrow stream.
- Assembles each frame into the 512-bit/64-bit buses GSIM consumes and issues a one-cycle start pulse.
- Holds the issued frame stable until GSIM reports completion; GSIM reads i_a/i_b combinationally throughout its run.
- Double-buffered: the next frame loads while the current one is solving. Frames with a zero diagonal element are rejected before issue.

---
 rtl/gsim_pkg.sv | 27 ++
 rtl/gsim_frame_loader_if.sv | 26 ++
 rtl/gsim_row_buffer.sv | 90 +++++++++
 rtl/gsim_frame_loader.sv | 85 ++++++++
 tb/tb_gsim_frame_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gsim_pkg.sv
// Shared widths, bus payload types and issue-state encoding for the GSIM frame loader.
package gsim_pkg;

  localparam int unsigned N_ROWS = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROW_W  = N_ROWS * DATA_W;
  localparam int unsigned MAT_W  = N_ROWS * ROW_W;
  localparam int unsigned VEC_W  = N_ROWS * DATA_W;
  localparam int unsigned CNT_W  = $clog2(N_ROWS);

  // Element 0 (row 0 / column 0) sits in the most significant slot of each bus.
  typedef logic [N_ROWS-1:0][ROW_W-1:0]  mat_t;
  typedef logic [N_ROWS-1:0][DATA_W-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } issue_state_e;

  // Element idx of a row, counted from the MSB end.
  function automatic logic [DATA_W-1:0] row_elem(input logic [ROW_W-1:0] row,
                                                 input logic [CNT_W-1:0] idx);
    return DATA_W'(row >> (ROW_W - DATA_W * (32'(idx) + 32'd1)));
  endfunction

endpackage

// File: rtl/gsim_frame_loader_if.sv
// Row stream in, GSIM frame/start/done out: everything the loader exchanges with its neighbours.
interface gsim_frame_loader_if;
  import gsim_pkg::*;

  logic               i_row_valid;
  logic               o_row_ready;
  logic [ROW_W-1:0]   i_row_a;
  logic [DATA_W-1:0]  i_row_b;
  logic               o_valid;
  logic [MAT_W-1:0]   o_a;
  logic [VEC_W-1:0]   o_b;
  logic               i_done;
  logic               o_busy;
  logic               o_diag_err;

  modport slave (
    input  i_row_valid, i_row_a, i_row_b, i_done,
    output o_row_ready, o_valid, o_a, o_b, o_busy, o_diag_err
  );

  modport master (
    output i_row_valid, i_row_a, i_row_b, i_done,
    input  o_row_ready, o_valid, o_a, o_b, o_busy, o_diag_err
  );

endinterface

// File: rtl/gsim_row_buffer.sv
// Shadow frame store: collects 8 rows, screens the diagonal, and flags a complete frame.
module gsim_row_buffer
  import gsim_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_row_valid,
  input  logic [ROW_W-1:0]  i_row_a,
  input  logic [DATA_W-1:0] i_row_b,
  input  logic              i_take,
  output logic              o_row_ready,
  output logic              o_shadow_full,
  output mat_t              o_shadow_a,
  output vec_t              o_shadow_b,
  output logic              o_diag_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic             full_q, full_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  mat_t             sa_q, sa_d;
  vec_t             sb_q, sb_d;

  logic             accept_c;
  logic             diag_zero_c;
  logic             last_c;
  logic [CNT_W-1:0] slot_c;

  always_comb begin
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    full_d  = full_q;
    err_d   = 1'b0;
    sa_d    = sa_q;
    sb_d    = sb_q;

    accept_c    = i_row_valid & ready_q;
    diag_zero_c = (row_elem(i_row_a, cnt_q) == '0);
    last_c      = (cnt_q == CNT_W'(N_ROWS - 1));
    slot_c      = CNT_W'(N_ROWS - 1) - cnt_q;

    // Take and accept are mutually exclusive: take needs full, accept needs not-full.
    if (i_take) full_d = 1'b0;

    if (accept_c) begin
      sa_d[slot_c] = i_row_a;
      sb_d[slot_c] = i_row_b;
      if (last_c) begin
        cnt_d = '0;
        bad_d = 1'b0;
        if (bad_q | diag_zero_c) err_d = 1'b1;
        else                     full_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        bad_d = bad_q | diag_zero_c;
      end
    end

    ready_d = ~full_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      sa_q    <= '0;
      sb_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign o_row_ready   = ready_q;
  assign o_shadow_full = full_q;
  assign o_shadow_a    = sa_q;
  assign o_shadow_b    = sb_q;
  assign o_diag_err    = err_q;

endmodule

// File: rtl/gsim_frame_loader.sv
// Double-buffered GSIM feeder: shadow buffer fills while the active frame is held for the solver.
module gsim_frame_loader
  import gsim_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  gsim_frame_loader_if.slave  bus
);

  logic         shadow_full;
  mat_t         shadow_a;
  vec_t         shadow_b;
  logic         row_ready;
  logic         diag_err;
  logic         take_c;

  issue_state_e state_q, state_d;
  mat_t         active_a_q, active_a_d;
  vec_t         active_b_q, active_b_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  gsim_row_buffer u_row_buffer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_row_valid   (bus.i_row_valid),
    .i_row_a       (bus.i_row_a),
    .i_row_b       (bus.i_row_b),
    .i_take        (take_c),
    .o_row_ready   (row_ready),
    .o_shadow_full (shadow_full),
    .o_shadow_a    (shadow_a),
    .o_shadow_b    (shadow_b),
    .o_diag_err    (diag_err)
  );

  assign take_c = (state_q == ST_IDLE) & shadow_full;

  // Issue FSM; outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d    = state_q;
    active_a_d = active_a_q;
    active_b_d = active_b_q;

    case (state_q)
      ST_IDLE: begin
        if (shadow_full) begin
          active_a_d = shadow_a;
          active_b_d = shadow_b;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY:  if (bus.i_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      active_a_q <= '0;
      active_b_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_a_q <= active_a_d;
      active_b_q <= active_b_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_row_ready = row_ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_a         = active_a_q;
  assign bus.o_b         = active_b_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_diag_err  = diag_err;

endmodule

// File: tb/tb_gsim_frame_loader.sv
// Directed bench for gsim_frame_loader: hand-built frames, expected buses rebuilt from element values.
module tb_gsim_frame_loader;

  logic i_clk;
  logic i_reset;

  gsim_frame_loader_if bus ();

  gsim_frame_loader dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int vectors = 0;
  int fails   = 0;

  int valid_cnt = 0;
  int acc_cnt   = 0;
  int err_cnt   = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Event counters sampled at the active edge (pre-update values).
  always @(posedge i_clk) begin
    if (!i_reset) begin
      if (bus.o_valid)                        valid_cnt = valid_cnt + 1;
      if (bus.i_row_valid && bus.o_row_ready) acc_cnt   = acc_cnt + 1;
      if (bus.o_diag_err)                     err_cnt   = err_cnt + 1;
    end
  end

  function automatic logic [63:0] mk_row(input int n, input logic [7:0] dg, input logic [7:0] off);
    logic [63:0] r;
    for (int m = 0; m < 8; m++) r[63-8*m -: 8] = (m == n) ? dg : off;
    return r;
  endfunction

  function automatic logic [511:0] mk_mat(input logic [7:0] dg, input logic [7:0] off);
    logic [511:0] r;
    for (int n = 0; n < 8; n++) r[511-64*n -: 64] = mk_row(n, dg, off);
    return r;
  endfunction

  function automatic logic [63:0] mk_vec(input logic [7:0] base);
    logic [63:0] r;
    for (int n = 0; n < 8; n++) r[63-8*n -: 8] = base + 8'(n);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams 8 rows back to back; returns at the negedge right after the 8th accept edge.
  task automatic send_frame(input logic [7:0] dg, input logic [7:0] off, input logic [7:0] bb,
                            input int zr);
    for (int n = 0; n < 8; n++) begin
      bus.i_row_valid = 1'b1;
      bus.i_row_a     = mk_row(n, (n == zr) ? 8'h00 : dg, off);
      bus.i_row_b     = bb + 8'(n);
      @(negedge i_clk);
    end
    bus.i_row_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.i_done = 1'b1;
    @(negedge i_clk);
    bus.i_done = 1'b0;
  endtask

  int v0, a0, e0;
  logic [511:0] mat_a, mat_b, mat_c, mat_e;
  logic [63:0]  vec_a, vec_b, vec_c, vec_e;
  logic [511:0] oa;

  initial begin
    mat_a = mk_mat(8'h20, 8'h03); vec_a = mk_vec(8'h11);
    mat_b = mk_mat(8'h30, 8'h05); vec_b = mk_vec(8'h21);
    mat_c = mk_mat(8'h7f, 8'h80); vec_c = mk_vec(8'hf0);
    mat_e = mk_mat(8'h11, 8'h00); vec_e = mk_vec(8'h00);

    i_reset         = 1'b1;
    bus.i_row_valid = 1'b0;
    bus.i_row_a     = '0;
    bus.i_row_b     = '0;
    bus.i_done      = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 512'(bus.o_row_ready), 512'(0));
    chk("rst_valid", 512'(bus.o_valid), 512'(0));
    chk("rst_busy",  512'(bus.o_busy), 512'(0));
    chk("rst_err",   512'(bus.o_diag_err), 512'(0));
    chk("rst_a",     bus.o_a, 512'(0));
    chk("rst_b",     512'(bus.o_b), 512'(0));
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("post_rst_ready", 512'(bus.o_row_ready), 512'(1));

    // Basic frame: diag 0x10, off 0x01, b = 1..8
    a0 = acc_cnt; v0 = valid_cnt;
    send_frame(8'h10, 8'h01, 8'h01, -1);
    chk("f1_accepts", 512'(acc_cnt - a0), 512'(8));
    chk("f1_ready_full", 512'(bus.o_row_ready), 512'(0));
    chk("f1_valid_early", 512'(bus.o_valid), 512'(0));
    @(negedge i_clk);
    oa = bus.o_a;
    chk("f1_valid", 512'(bus.o_valid), 512'(1));
    chk("f1_busy", 512'(bus.o_busy), 512'(1));
    chk("f1_a00", 512'(oa[511:504]), 512'(8'h10));
    chk("f1_a01", 512'(oa[503:496]), 512'(8'h01));
    chk("f1_a", bus.o_a, mk_mat(8'h10, 8'h01));
    chk("f1_b", 512'(bus.o_b), 512'(64'h0102030405060708));
    chk("f1_ready_free", 512'(bus.o_row_ready), 512'(1));
    @(negedge i_clk);
    chk("f1_valid_drop", 512'(bus.o_valid), 512'(0));
    repeat (3) @(negedge i_clk);
    chk("f1_busy_hold", 512'(bus.o_busy), 512'(1));
    chk("f1_one_pulse", 512'(valid_cnt - v0), 512'(1));
    pulse_done();
    chk("f1_idle", 512'(bus.o_busy), 512'(0));
    @(negedge i_clk);

    // Zero diagonal in row 3: frame dropped
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h20, 8'h03, 8'h11, 3);
    chk("d3_err", 512'(bus.o_diag_err), 512'(1));
    chk("d3_ready", 512'(bus.o_row_ready), 512'(1));
    @(negedge i_clk);
    chk("d3_err_drop", 512'(bus.o_diag_err), 512'(0));
    chk("d3_ready2", 512'(bus.o_row_ready), 512'(1));
    repeat (3) @(negedge i_clk);
    chk("d3_no_valid", 512'(valid_cnt - v0), 512'(0));
    chk("d3_one_err", 512'(err_cnt - e0), 512'(1));
    chk("d3_idle", 512'(bus.o_busy), 512'(0));

    // Zero diagonal on the last row itself
    send_frame(8'h20, 8'h03, 8'h11, 7);
    chk("d7_err", 512'(bus.o_diag_err), 512'(1));
    @(negedge i_clk);
    chk("d7_no_valid", 512'(valid_cnt - v0), 512'(0));

    // Next valid frame (A) issues normally
    send_frame(8'h20, 8'h03, 8'h11, -1);
    @(negedge i_clk);
    chk("fa_valid", 512'(bus.o_valid), 512'(1));
    chk("fa_a", bus.o_a, mat_a);
    chk("fa_b", 512'(bus.o_b), 512'(vec_a));
    @(negedge i_clk);

    // Frame B streamed while A solves; C row 0 then held against a stalled stream
    a0 = acc_cnt;
    send_frame(8'h30, 8'h05, 8'h21, -1);
    bus.i_row_valid = 1'b1;
    bus.i_row_a     = mk_row(0, 8'h7f, 8'h80);
    bus.i_row_b     = 8'hf0;
    chk("fb_ready_low", 512'(bus.o_row_ready), 512'(0));
    chk("fb_a_held", bus.o_a, mat_a);
    repeat (5) @(negedge i_clk);
    chk("stall_ready", 512'(bus.o_row_ready), 512'(0));
    chk("stall_accepts", 512'(acc_cnt - a0), 512'(8));
    chk("stall_a_held", bus.o_a, mat_a);
    chk("stall_b_held", 512'(bus.o_b), 512'(vec_a));
    pulse_done();
    chk("fb_gap_valid", 512'(bus.o_valid), 512'(0));
    chk("fb_gap_busy", 512'(bus.o_busy), 512'(0));
    @(negedge i_clk);
    chk("fb_valid", 512'(bus.o_valid), 512'(1));
    chk("fb_a", bus.o_a, mat_b);
    chk("fb_b", 512'(bus.o_b), 512'(vec_b));
    chk("fb_ready_back", 512'(bus.o_row_ready), 512'(1));
    @(negedge i_clk);
    for (int n = 1; n < 8; n++) begin
      bus.i_row_a = mk_row(n, 8'h7f, 8'h80);
      bus.i_row_b = 8'hf0 + 8'(n);
      @(negedge i_clk);
    end
    bus.i_row_valid = 1'b0;
    chk("fc_accepts", 512'(acc_cnt - a0), 512'(16));
    chk("fc_ready_low", 512'(bus.o_row_ready), 512'(0));
    chk("fc_a_still_b", bus.o_a, mat_b);
    pulse_done();
    @(negedge i_clk);
    chk("fc_valid", 512'(bus.o_valid), 512'(1));
    chk("fc_a", bus.o_a, mat_c);
    chk("fc_b", 512'(bus.o_b), 512'(vec_c));

    // i_done during ISSUE is ignored
    pulse_done();
    chk("issue_done_ignored", 512'(bus.o_busy), 512'(1));
    pulse_done();
    chk("fc_idle", 512'(bus.o_busy), 512'(0));

    // Reset after 5 rows drops the partial frame
    v0 = valid_cnt; e0 = err_cnt;
    for (int n = 0; n < 5; n++) begin
      bus.i_row_valid = 1'b1;
      bus.i_row_a     = mk_row(n, 8'h55, 8'h66);
      bus.i_row_b     = 8'h40 + 8'(n);
      @(negedge i_clk);
    end
    bus.i_row_valid = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_ready", 512'(bus.o_row_ready), 512'(0));
    chk("mid_rst_a", bus.o_a, 512'(0));
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_ready_back", 512'(bus.o_row_ready), 512'(1));
    send_frame(8'h11, 8'h00, 8'h00, -1);
    @(negedge i_clk);
    chk("fe_valid", 512'(bus.o_valid), 512'(1));
    chk("fe_a", bus.o_a, mat_e);
    chk("fe_b", 512'(bus.o_b), 512'(vec_e));
    repeat (3) @(negedge i_clk);
    chk("fe_one_pulse", 512'(valid_cnt - v0), 512'(1));
    chk("fe_no_err", 512'(err_cnt - e0), 512'(0));
    pulse_done();
    chk("fe_idle", 512'(bus.o_busy), 512'(0));

    // i_done in IDLE with an idle stream
    v0 = valid_cnt;
    pulse_done();
    repeat (20) @(negedge i_clk);
    chk("idle_no_valid", 512'(valid_cnt - v0), 512'(0));
    chk("idle_busy", 512'(bus.o_busy), 512'(0));
    chk("idle_ready", 512'(bus.o_row_ready), 512'(1));
    chk("idle_a_held", bus.o_a, mat_e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
